cmp_result_monitor: RTL
=======================

Name: cmp_result_monitor

Overview:
Downstream consumer of the 1-bit comparator's gt/ls/eq result flags. Samples one result per qualified cycle and keeps saturating per-outcome tallies. Tracks the length of the current run of identical outcomes and raises an alert when a run reaches a programmable length. Flags malformed (non-one-hot) result codes, giving verification and system logic a registered summary of comparator activity.

Parameters:
CNT_W, 8, width of each tally counter and of run_len; all counters saturate at 2^CNT_W-1
RUN_LEN, 4, run length at which run_alert asserts; legal range 2 to 2^CNT_W-1

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
clr  input  1  synchronous soft clear of all state, same effect as rst
in_valid  input  1  qualifies gt/ls/eq this cycle
gt  input  1  comparator result a>b
ls  input  1  comparator result a<b
eq  input  1  comparator result a==b
gt_cnt  output  CNT_W  number of accepted gt samples
ls_cnt  output  CNT_W  number of accepted ls samples
eq_cnt  output  CNT_W  number of accepted eq samples
run_len  output  CNT_W  length of the current run of identical outcomes
cur_code  output  2  last accepted outcome: 00 none, 01 gt, 10 ls, 11 eq
run_alert  output  1  high while the current run is at least RUN_LEN long
err  output  1  sticky flag: a non-one-hot sample was seen

Behaviour:
- Reset values (rst, or clr): all counters 0, run_len 0, cur_code 00, run_alert 0, err 0, FSM in IDLE.
- Priority: rst > clr > in_valid. A sample presented in a clr cycle is discarded.
- All outputs are registered. A sample accepted at edge k is reflected in the outputs immediately after edge k, giving a latency of 1 cycle.
- in_valid=0: all state holds.
- Accepted sample: in_valid=1 and exactly one of gt/ls/eq is high. The matching tally increments and saturates, with no wrap.
- Malformed sample: in_valid=1 and zero, two, or three flags high.
  - err is set and stays set until rst or clr.
  - Tallies, run_len, cur_code and the FSM do not change.
- FSM states:
  - IDLE: no accepted sample since reset or clear.
  - TRACK: run_len < RUN_LEN.
  - ALERT: run_len >= RUN_LEN.
- FSM transitions:
  - IDLE, on an accepted sample: go to TRACK, run_len=1, cur_code=code.
  - TRACK or ALERT, accepted code == cur_code: run_len+1, saturating at 2^CNT_W-1. Enter or stay in ALERT when the new run_len >= RUN_LEN.
  - TRACK or ALERT, accepted code != cur_code: go to TRACK, run_len=1, cur_code=new code.
- run_alert = (state == ALERT), registered. It asserts on the same edge that run_len reaches RUN_LEN and deasserts on the edge that accepts a differing code.
- Saturated run_len stays in ALERT while the same code continues.
- Back-to-back valid samples on consecutive cycles are fully supported. There is no backpressure; the block always accepts.

Test Plan:
- Reset, then hold in_valid=0 for 5 cycles -> all counters 0, cur_code=00, run_alert=0, err=0.
- Default parameters, 4 consecutive eq samples -> eq_cnt steps 1,2,3,4. run_len steps 1,2,3,4. run_alert rises 1 cycle after the 4th sample. cur_code=11.
- Sequence gt,gt,gt,gt,ls -> run_alert=1 after the 4th sample. After ls: run_alert=0, run_len=1, cur_code=10, gt_cnt=4, ls_cnt=1.
- Between valid gt samples, insert a sample with gt=1,eq=1 and a sample with all flags 0 -> err=1 and stays 1. gt_cnt and run_len count only the valid gt samples; run_len is unaffected by the bad samples.
- CNT_W=4, 20 consecutive ls samples -> ls_cnt and run_len saturate at 15, run_alert remains 1. Assert clr for one cycle together with a gt sample -> all outputs 0 next cycle, and the gt sample is not counted.
- Mid-run, assert rst while in_valid=1 with a valid sample -> reset values next cycle, sample ignored. The next accepted sample gives run_len=1 from IDLE.

Source files
------------

// File: rtl/cmp_result_monitor.sv
// Result monitor for a 1-bit comparator: saturating per-outcome tallies, run-length
// tracking with a programmable alert threshold, and a sticky malformed-code flag.
module cmp_result_monitor #(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             gt,
  input  logic             ls,
  input  logic             eq,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] ls_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] run_len,
  output logic [1:0]       cur_code,
  output logic             run_alert,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_THR = CNT_W'(RUN_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    ALERT = 2'b10
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_W-1:0] ls_cnt_q, ls_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic [1:0]       cur_code_q, cur_code_d;
  logic             run_alert_q, run_alert_d;
  logic             err_q, err_d;
  logic [1:0]       code_s;
  logic             one_hot_s;

  // Decode the flag triple into an outcome code; anything not one-hot is malformed.
  always_comb begin
    code_s    = 2'b00;
    one_hot_s = 1'b0;
    case ({gt, ls, eq})
      3'b100:  begin code_s = 2'b01; one_hot_s = 1'b1; end
      3'b010:  begin code_s = 2'b10; one_hot_s = 1'b1; end
      3'b001:  begin code_s = 2'b11; one_hot_s = 1'b1; end
      default: begin code_s = 2'b00; one_hot_s = 1'b0; end
    endcase
  end

  // Next-state: tallies, run tracking and error flag.
  always_comb begin
    state_d    = state_q;
    gt_cnt_d   = gt_cnt_q;
    ls_cnt_d   = ls_cnt_q;
    eq_cnt_d   = eq_cnt_q;
    run_len_d  = run_len_q;
    cur_code_d = cur_code_q;
    err_d      = err_q;
    if (in_valid && one_hot_s) begin
      case (code_s)
        2'b01:   gt_cnt_d = sat_inc(gt_cnt_q);
        2'b10:   ls_cnt_d = sat_inc(ls_cnt_q);
        2'b11:   eq_cnt_d = sat_inc(eq_cnt_q);
        default: gt_cnt_d = gt_cnt_q;
      endcase
      // IDLE holds cur_code 00, which never matches a real outcome.
      if (state_q == IDLE || code_s != cur_code_q) begin
        run_len_d  = ONE;
        cur_code_d = code_s;
        state_d    = TRACK;
      end else begin
        run_len_d = sat_inc(run_len_q);
        state_d   = (run_len_d >= RUN_THR) ? ALERT : TRACK;
      end
    end else if (in_valid) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    run_alert_d = (state_d == ALERT);
  end

  // State and output registers; rst and clr both return to the idle values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q     <= IDLE;
      gt_cnt_q    <= '0;
      ls_cnt_q    <= '0;
      eq_cnt_q    <= '0;
      run_len_q   <= '0;
      cur_code_q  <= 2'b00;
      run_alert_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gt_cnt_q    <= gt_cnt_d;
      ls_cnt_q    <= ls_cnt_d;
      eq_cnt_q    <= eq_cnt_d;
      run_len_q   <= run_len_d;
      cur_code_q  <= cur_code_d;
      run_alert_q <= run_alert_d;
      err_q       <= err_d;
    end
  end

  assign gt_cnt    = gt_cnt_q;
  assign ls_cnt    = ls_cnt_q;
  assign eq_cnt    = eq_cnt_q;
  assign run_len   = run_len_q;
  assign cur_code  = cur_code_q;
  assign run_alert = run_alert_q;
  assign err       = err_q;

endmodule
